wormhole_out_arbiter: RTL and testbench

- Packet-aware arbiter that shares one router output link between N input ports.
- Picks the highest-priority head flit (CMP field) with round-robin tie-break, then locks the link to that port until the packet's tail.
- Credit-based flow control toward the downstream buffer; one registered output stage.
- Sits between the per-port input buffers and the output link of the dynamic router.

---
 rtl/wormhole_out_arbiter_pkg.sv | 33 +++
 rtl/wormhole_out_arbiter_rr_prio_pick.sv | 40 ++++
 rtl/wormhole_out_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wormhole_out_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wormhole_out_arbiter_pkg.sv
// Shared flit format, arbiter state type and flit decode helpers for wormhole_out_arbiter.
package wormhole_out_arbiter_pkg;

    localparam int FLIT_SIZE  = 32;
    localparam int HEADER_LEN = 2;
    localparam int CMP_LEN    = 3;
    localparam int CMP_POS    = FLIT_SIZE - HEADER_LEN - 1;

    typedef logic [HEADER_LEN-1:0] flit_type_t;

    localparam flit_type_t SINGLE_FLIT = 2'b00;
    localparam flit_type_t HEAD_FLIT   = 2'b01;
    localparam flit_type_t BODY_FLIT   = 2'b10;
    localparam flit_type_t TAIL_FLIT   = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic flit_type_t flit_type(input logic [FLIT_SIZE-1:0] flit);
        return flit[FLIT_SIZE-1 -: HEADER_LEN];
    endfunction

    function automatic logic [CMP_LEN-1:0] flit_cmp(input logic [FLIT_SIZE-1:0] flit);
        return flit[CMP_POS -: CMP_LEN];
    endfunction

    function automatic logic starts_packet(input flit_type_t t);
        return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
    endfunction

endpackage

// File: rtl/wormhole_out_arbiter_rr_prio_pick.sv
// Combinational pick of the highest CMP value in an eligible mask; ties resolve to the
// first eligible port in cyclic order starting at rr_ptr_i.
module wormhole_out_arbiter_rr_prio_pick
    import wormhole_out_arbiter_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         elig_i,
    input  logic [N*CMP_LEN-1:0] cmp_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic [IDX_W-1:0]     winner_o,
    output logic                 any_o
);

    logic [CMP_LEN-1:0] cmp_a [N];
    logic [CMP_LEN-1:0] best;
    logic [IDX_W-1:0]   idx;

    for (genvar i = 0; i < N; i++) begin : g_cmp
        assign cmp_a[i] = cmp_i[i*CMP_LEN +: CMP_LEN];
    end

    // Strict '>' keeps the earliest port in rotation order when CMP values tie.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        best     = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(rr_ptr_i) + k) % N);
            if (elig_i[idx] && (!any_o || (cmp_a[idx] > best))) begin
                any_o    = 1'b1;
                best     = cmp_a[idx];
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/wormhole_out_arbiter.sv
// Packet-aware output-link arbiter: CMP priority with round-robin tie-break, wormhole lock
// until TAIL, credit flow control. Optional starvation guard via macro WOA_AGING_EN.
module wormhole_out_arbiter
    import wormhole_out_arbiter_pkg::*;
#(
    parameter  int N          = 4,
    parameter  int CREDIT_MAX = 8,
`ifdef WOA_AGING_EN
    parameter  int AGE_LIMIT  = 15,
`endif
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_SIZE*N-1:0] in_flit,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    input  logic                   credit_in,
    output logic [FLIT_SIZE-1:0]   out_flit,
    output logic                   out_valid,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   proto_err
);

    localparam int CW = $clog2(CREDIT_MAX + 1);
    localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [CW-1:0]        cred_q, cred_d;
    logic                 bubble_q, bubble_d;
    logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
    logic                 out_valid_q, out_valid_d;
    logic                 perr_q, perr_d;

    logic [FLIT_SIZE-1:0] flit_a [N];
    logic [N-1:0]         elig;
    logic [N*CMP_LEN-1:0] cmp_flat;
    logic [N-1:0]         pick_mask;
    logic [N*CMP_LEN-1:0] pick_cmp;
    logic [IDX_W-1:0]     winner;
    logic                 any_elig;
    logic [IDX_W-1:0]     sel;
    logic [FLIT_SIZE-1:0] sel_flit;
    flit_type_t           sel_type;
    logic                 xfer;
    logic                 can_send;
    logic                 credit_ok;

    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_port
        assign flit_a[i] = in_flit[i*FLIT_SIZE +: FLIT_SIZE];
        assign elig[i]   = in_valid[i] && starts_packet(flit_type(flit_a[i]));
        assign cmp_flat[i*CMP_LEN +: CMP_LEN] = flit_cmp(flit_a[i]);
    end

`ifdef WOA_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [AW-1:0] wait_q [N];
    logic [N-1:0]  aged;

    for (genvar i = 0; i < N; i++) begin : g_age
        assign aged[i] = elig[i] && (wait_q[i] == AGE_MAX);
    end

    // Aged ports win outright; zeroed CMP leaves the choice among them to rotation.
    assign pick_mask = (|aged) ? aged : elig;
    assign pick_cmp  = (|aged) ? '0 : cmp_flat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) wait_q[i] <= '0;
        end else if (state_q == IDLE) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i] && !(xfer && (sel == IDX_W'(i)))) begin
                    if (wait_q[i] != AGE_MAX) wait_q[i] <= wait_q[i] + 1'b1;
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end
`else
    assign pick_mask = elig;
    assign pick_cmp  = cmp_flat;
`endif

    wormhole_out_arbiter_rr_prio_pick #(.N(N)) u_pick (
        .elig_i   (pick_mask),
        .cmp_i    (pick_cmp),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_elig)
    );

    assign can_send  = (cred_q != '0);
    assign credit_ok = credit_in && (cred_q != CRED_FULL);

    // The IDLE cycle right after a packet end is a pure re-arbitration cycle (no grant).
    always_comb begin
        in_ready = '0;
        sel      = owner_q;
        if (state_q == IDLE) begin
            sel = winner;
            if (any_elig && can_send && !bubble_q) in_ready[winner] = 1'b1;
        end else begin
            in_ready[owner_q] = can_send;
        end
    end

    assign xfer     = |(in_valid & in_ready);
    assign sel_flit = flit_a[sel];
    assign sel_type = flit_type(sel_flit);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        bubble_d    = 1'b0;
        perr_d      = credit_in && !credit_ok;
        out_valid_d = xfer;
        out_flit_d  = xfer ? sel_flit : out_flit_q;

        cred_d = cred_q;
        if (xfer && !credit_ok)      cred_d = cred_q - 1'b1;
        else if (!xfer && credit_ok) cred_d = cred_q + 1'b1;

        if (xfer) begin
            grant_d = sel;
            if (state_q == IDLE) begin
                if (sel_type == HEAD_FLIT) begin
                    state_d = LOCKED;
                    owner_d = sel;
                end else begin
                    rr_ptr_d = next_port(sel);
                end
            end else if (sel_type != BODY_FLIT) begin
                // TAIL ends the packet; a HEAD/SINGLE from the owner also ends it, as an error.
                state_d  = IDLE;
                rr_ptr_d = next_port(owner_q);
                bubble_d = 1'b1;
                if (sel_type != TAIL_FLIT) perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cred_q      <= CRED_FULL;
            bubble_q    <= 1'b0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cred_q      <= cred_d;
            bubble_q    <= bubble_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            perr_q      <= perr_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == LOCKED);
    assign proto_err = perr_q;

endmodule

// File: tb/tb_wormhole_out_arbiter.sv
// Bench for wormhole_out_arbiter: vector table, corner sequences and a randomized reference model.
module tb_wormhole_out_arbiter;
    import wormhole_out_arbiter_pkg::*;

    localparam int N       = 4;
    localparam int AGE_LIM = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [FLIT_SIZE*N-1:0] in_flit = '0;
    logic [N-1:0]           in_valid = '0;
    logic                   credit_in = 1'b0;

    logic [N-1:0]  ready_a, ready_b;
    logic [31:0]   oflit_a, oflit_b;
    logic          ov_a, ov_b, busy_a, busy_b, perr_a, perr_b;
    logic [1:0]    gid_a, gid_b;

    wormhole_out_arbiter #(.N(N), .CREDIT_MAX(8)
`ifdef WOA_AGING_EN
        , .AGE_LIMIT(AGE_LIM)
`endif
    ) dut_a (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(ready_a),
        .credit_in(credit_in), .out_flit(oflit_a), .out_valid(ov_a), .grant_id(gid_a),
        .busy(busy_a), .proto_err(perr_a)
    );

    wormhole_out_arbiter #(.N(N), .CREDIT_MAX(2)
`ifdef WOA_AGING_EN
        , .AGE_LIMIT(AGE_LIM)
`endif
    ) dut_b (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(ready_b),
        .credit_in(credit_in), .out_flit(oflit_b), .out_valid(ov_b), .grant_id(gid_b),
        .busy(busy_b), .proto_err(perr_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] c, input int pay);
        logic [31:0] p;
        p = pay;
        return {t, c, p[26:0]};
    endfunction

    typedef struct {
        bit           rs;
        logic [3:0]   v;
        logic [127:0] f;
        logic         cr;
        logic [3:0]   er;
        logic         eov;
        logic [31:0]  efl;
        logic [1:0]   eg;
        logic         eb;
        logic         ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit rs, logic [3:0] v, logic [127:0] f, logic cr, logic [3:0] er,
                               logic eov, logic [31:0] efl, logic [1:0] eg, logic eb, logic ep);
        vec_t x;
        x.rs = rs; x.v = v; x.f = f; x.cr = cr; x.er = er;
        x.eov = eov; x.efl = efl; x.eg = eg; x.eb = eb; x.ep = ep;
        return x;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        in_valid = '0;
        credit_in = 1'b0;
        in_flit = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Reference model state
    bit          m_lock, m_hold;
    int          m_owner, m_rr, m_cred, m_gid;
    int          m_wait [N];
    logic [31:0] fl [N];
    int          key [N];
    bit          m_elig [N];
    bit          pool [N];

    logic [31:0] s1, s2, h0, bo1, bo2, t0, h3, t3, hd1, hd1b, sg1;
    logic [31:0] e [N];
    logic [31:0] z;
    int          acc;

    initial begin
        z = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_grant", 32'(gid_a), 32'd0);
        chk("rst_perr", 32'(perr_a), 32'd0);
        chk("rst_out_flit", oflit_a, 32'd0);
        chk("rst_ready", 32'(ready_a), 32'd0);

        s1 = mk(SINGLE_FLIT, 3, 1);  s2 = mk(SINGLE_FLIT, 7, 2);
        h0 = mk(HEAD_FLIT, 1, 16);   bo1 = mk(BODY_FLIT, 0, 17); bo2 = mk(BODY_FLIT, 0, 18);
        t0 = mk(TAIL_FLIT, 0, 19);   h3 = mk(HEAD_FLIT, 5, 48);  t3 = mk(TAIL_FLIT, 0, 49);
        hd1 = mk(HEAD_FLIT, 2, 64);  hd1b = mk(HEAD_FLIT, 2, 65); sg1 = mk(SINGLE_FLIT, 2, 66);
        for (int i = 0; i < N; i++) e[i] = mk(SINGLE_FLIT, 4, 32 + i);

        // CMP priority among SINGLEs
        tbl.push_back(V(1, 4'b0110, {z, s2, s1, z}, 0, 4'b0100, 1, s2, 2, 0, 0));
        tbl.push_back(V(0, 4'b0010, {z, s2, s1, z}, 0, 4'b0010, 1, s1, 1, 0, 0));
        tbl.push_back(V(0, 4'b0000, {z, z, z, z},   0, 4'b0000, 0, z,  1, 0, 0));
        // wormhole lock against a higher-CMP HEAD, bubble after TAIL
        tbl.push_back(V(1, 4'b0001, {z, z, z, h0},   0, 4'b0001, 1, h0,  0, 1, 0));
        tbl.push_back(V(0, 4'b1001, {h3, z, z, bo1}, 0, 4'b0001, 1, bo1, 0, 1, 0));
        tbl.push_back(V(0, 4'b1001, {h3, z, z, bo2}, 0, 4'b0001, 1, bo2, 0, 1, 0));
        tbl.push_back(V(0, 4'b1001, {h3, z, z, t0},  0, 4'b0001, 1, t0,  0, 0, 0));
        tbl.push_back(V(0, 4'b1000, {h3, z, z, z},   0, 4'b0000, 0, z,   0, 0, 0));
        tbl.push_back(V(0, 4'b1000, {h3, z, z, z},   0, 4'b1000, 1, h3,  3, 1, 0));
        tbl.push_back(V(0, 4'b1000, {t3, z, z, z},   0, 4'b1000, 1, t3,  3, 0, 0));
        // round-robin among equal CMP
        tbl.push_back(V(1, 4'b1111, {e[3], e[2], e[1], e[0]}, 0, 4'b0001, 1, e[0], 0, 0, 0));
        tbl.push_back(V(0, 4'b1111, {e[3], e[2], e[1], e[0]}, 0, 4'b0010, 1, e[1], 1, 0, 0));
        tbl.push_back(V(0, 4'b1111, {e[3], e[2], e[1], e[0]}, 0, 4'b0100, 1, e[2], 2, 0, 0));
        tbl.push_back(V(0, 4'b1111, {e[3], e[2], e[1], e[0]}, 0, 4'b1000, 1, e[3], 3, 0, 0));
        tbl.push_back(V(0, 4'b1111, {e[3], e[2], e[1], e[0]}, 0, 4'b0001, 1, e[0], 0, 0, 0));
        // protocol errors: credit overflow, HEAD inside a packet
        tbl.push_back(V(1, 4'b0000, {z, z, z, z},    1, 4'b0000, 0, z,    0, 0, 1));
        tbl.push_back(V(0, 4'b0010, {z, z, hd1, z},  0, 4'b0010, 1, hd1,  1, 1, 0));
        tbl.push_back(V(0, 4'b0010, {z, z, hd1b, z}, 0, 4'b0010, 1, hd1b, 1, 0, 1));
        tbl.push_back(V(0, 4'b0010, {z, z, sg1, z},  0, 4'b0000, 0, z,    1, 0, 0));
        tbl.push_back(V(0, 4'b0010, {z, z, sg1, z},  0, 4'b0010, 1, sg1,  1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            in_valid = tbl[i].v;
            in_flit = tbl[i].f;
            credit_in = tbl[i].cr;
            #1 chk($sformatf("tbl%0d_ready", i), 32'(ready_a), 32'(tbl[i].er));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(ov_a), 32'(tbl[i].eov));
            if (tbl[i].eov) chk($sformatf("tbl%0d_out_flit", i), oflit_a, tbl[i].efl);
            chk($sformatf("tbl%0d_grant", i), 32'(gid_a), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_perr", i), 32'(perr_a), 32'(tbl[i].ep));
        end

        // Credit exhaustion on the 2-deep instance, then one credit pulse
        begin
            bit exp_r [7] = '{1, 1, 0, 0, 0, 1, 0};
            bit cr    [7] = '{0, 0, 0, 0, 1, 0, 0};
            do_reset();
            for (int k = 0; k < 7; k++) begin
                in_valid = 4'b0001;
                in_flit = {z, z, z, mk(SINGLE_FLIT, 0, 5 + k)};
                credit_in = cr[k];
                #1 chk($sformatf("cred%0d_ready", k), 32'(ready_b), 32'(exp_r[k]));
                @(posedge clk); #1;
                chk($sformatf("cred%0d_out_valid", k), 32'(ov_b), 32'(exp_r[k]));
            end
            credit_in = 1'b0;
        end

        // Reset in the middle of a packet
        do_reset();
        in_valid = 4'b0001;
        in_flit = {z, z, z, h0};
        @(posedge clk); #1;
        in_flit = {z, z, z, bo1};
        @(posedge clk); #1;
        chk("mid_busy_before", 32'(busy_a), 32'd1);
        in_flit = {z, z, z, bo2};
        #1 rst = 1'b0;
        #1;
        chk("mid_out_valid", 32'(ov_a), 32'd0);
        chk("mid_busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("mid_body_ready%0d", k), 32'(ready_a), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("mid_body_ov%0d", k), 32'(ov_a), 32'd0);
        end
        acc = 0;
        in_flit = {z, z, z, mk(SINGLE_FLIT, 0, 9)};
        for (int k = 0; k < 10; k++) begin
            #1 if (ready_a[0]) acc++;
            @(posedge clk); #1;
        end
        chk("mid_credits_after_reset", 32'(acc), 32'd8);

`ifdef WOA_AGING_EN
        // Starvation guard: CMP-1 port 0 against CMP-7 port 1
        begin
            logic [3:0] ag_exp [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
            do_reset();
            in_valid = 4'b0011;
            in_flit = {z, z, mk(SINGLE_FLIT, 7, 8), mk(SINGLE_FLIT, 1, 7)};
            for (int k = 0; k < 5; k++) begin
                #1 chk($sformatf("age%0d_ready", k), 32'(ready_a), 32'(ag_exp[k]));
                @(posedge clk); #1;
            end
        end
`endif

        // Randomized run against the reference model
        do_reset();
        m_lock = 0; m_hold = 0; m_owner = 0; m_rr = 0; m_cred = 8; m_gid = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        for (int it = 0; it < 400; it++) begin
            logic [3:0] exp_r;
            int  win, maxc, s;
            bit  x, e_perr, hold_n, any_aged;
            logic [1:0] t;
            for (int i = 0; i < N; i++) begin
                fl[i] = mk(2'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), int'($urandom_range(0, 9999)));
                in_valid[i] = ($urandom_range(0, 9) < 7);
            end
            in_flit = {fl[3], fl[2], fl[1], fl[0]};
            credit_in = $urandom_range(0, 1) == 1;

            for (int i = 0; i < N; i++) begin
                t = fl[i][31:30];
                m_elig[i] = in_valid[i] && (t == HEAD_FLIT || t == SINGLE_FLIT);
                key[i] = int'(fl[i][29:27]);
                pool[i] = m_elig[i];
            end
            any_aged = 0;
`ifdef WOA_AGING_EN
            for (int i = 0; i < N; i++) if (m_elig[i] && m_wait[i] == AGE_LIM) any_aged = 1;
            if (any_aged)
                for (int i = 0; i < N; i++) begin
                    pool[i] = m_elig[i] && m_wait[i] == AGE_LIM;
                    key[i] = 0;
                end
`endif
            exp_r = '0;
            win = -1;
            if (!m_lock) begin
                maxc = -1;
                for (int i = 0; i < N; i++) if (pool[i] && key[i] > maxc) maxc = key[i];
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_rr + k) % N;
                    if (win < 0 && pool[p] && key[p] == maxc) win = p;
                end
                if (win >= 0 && m_cred > 0 && !m_hold) exp_r[win] = 1'b1;
            end else begin
                exp_r[m_owner] = (m_cred > 0);
            end
            #1 chk($sformatf("rnd%0d_ready", it), 32'(ready_a), 32'(exp_r));
            @(posedge clk); #1;

            x = |(in_valid & exp_r);
            s = m_lock ? m_owner : win;
            e_perr = credit_in && (m_cred == 8);
            if (credit_in && m_cred < 8) m_cred++;
            if (x) m_cred--;
`ifdef WOA_AGING_EN
            if (!m_lock)
                for (int i = 0; i < N; i++)
                    m_wait[i] = (m_elig[i] && !(x && s == i)) ? ((m_wait[i] < AGE_LIM) ? m_wait[i] + 1 : AGE_LIM) : 0;
`endif
            hold_n = 0;
            if (x) begin
                t = fl[s][31:30];
                m_gid = s;
                if (!m_lock) begin
                    if (t == HEAD_FLIT) begin
                        m_lock = 1;
                        m_owner = s;
                    end else begin
                        m_rr = (s + 1) % N;
                    end
                end else if (t != BODY_FLIT) begin
                    m_lock = 0;
                    m_rr = (m_owner + 1) % N;
                    hold_n = 1;
                    if (t != TAIL_FLIT) e_perr = 1;
                end
            end
            m_hold = hold_n;
            chk($sformatf("rnd%0d_out_valid", it), 32'(ov_a), 32'(x));
            if (x) chk($sformatf("rnd%0d_out_flit", it), oflit_a, fl[s]);
            chk($sformatf("rnd%0d_grant", it), 32'(gid_a), 32'(m_gid));
            chk($sformatf("rnd%0d_busy", it), 32'(busy_a), 32'(m_lock));
            chk($sformatf("rnd%0d_perr", it), 32'(perr_a), 32'(e_perr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
